uart_receiver: RTL and testbench

Serial-to-parallel UART receive engine; the receive-side counterpart of the block's UART transmitter in the APB UART peripheral. Samples the `rx` line using the shared 16x oversampling tick, recovers 8N1 frames (LSB first), and presents each byte on `rx_dout` with a one-cycle `rx_done_tick` for the RX FIFO. Detects start-bit glitches and framing errors.

---
 rtl/uart_receiver.sv | 171 +++++++++++++++++
 tb/tb_uart_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine with 16x oversampling, start-glitch rejection and framing check.
// Optional even-parity check when UART_RX_PARITY_EN is defined (adds parity_err output).
module uart_receiver #(
  parameter int DBit = 8,
  parameter int SBit = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] rx_dout,
  output logic       rx_done_tick,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = (SBit > 16) ? 5 : 4;
  localparam logic [CW-1:0] MID_LAST  = CW'(7);
  localparam logic [CW-1:0] BIT_LAST  = CW'(15);
  localparam logic [CW-1:0] STOP_LAST = CW'(SBit - 1);
  localparam logic [2:0]    N_LAST    = 3'(DBit - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   s_cnt, s_cnt_n;
  logic [2:0]      n, n_n;
  logic [7:0]      b, b_n;
  logic [7:0]      dout_n;
  logic            done_n, ferr_n;
  logic [7:0]      rx_data;
`ifdef UART_RX_PARITY_EN
  logic            par_bad, par_bad_n, perr_n;
`endif

  // Data bits enter at the MSB, so after DBit shifts the byte sits in the top DBit bits.
  assign rx_data = b >> (8 - DBit);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      s_cnt        <= '0;
      n            <= '0;
      b            <= '0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      state        <= state_n;
      s_cnt        <= s_cnt_n;
      n            <= n_n;
      b            <= b_n;
      rx_dout      <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad      <= par_bad_n;
      parity_err   <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    n_n       = n;
    b_n       = b;
    dout_n    = rx_dout;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == MID_LAST) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              s_cnt_n = '0;
              n_n     = '0;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_n = '0;
            b_n     = {rx_s, b[7:1]};
            n_n     = n + 3'd1;
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_n   = '0;
            par_bad_n = rx_s ^ (^rx_data);
            state_n   = STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            if (rx_s) begin
              dout_n = rx_data;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_n = par_bad;
`endif
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a frame-level reference model.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
module tb_uart_receiver;

  localparam int DBIT = 8;
  localparam logic [7:0] MASK = 8'((1 << DBIT) - 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_receiver #(.DBit(DBIT), .SBit(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Oversampling tick: one clk-wide pulse every tick_period clocks, changed on falling edges.
  int tick_period = 4;
  initial begin
    int div;
    div    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      div++;
      if (div >= tick_period) div = 0;
      s_tick = (div == 0);
    end
  end

  int unsigned tick_total = 0;
  always @(posedge clk) if (s_tick) tick_total <= tick_total + 1;

  // Observation side
  logic [7:0]  obs_q[$];
  int          ferr_seen = 0;
  int          perr_seen = 0;
  int unsigned start_tick = 0;
  int unsigned last_lat = 0;
  logic        prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (rx_done_tick || frame_err)
      check("single_pulse", {30'd0, prev_pulse, rx_done_tick & frame_err}, 32'd0);
    if (rx_done_tick) begin
      obs_q.push_back(rx_dout);
      last_lat = tick_total - start_tick;
    end
    if (frame_err) ferr_seen++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_seen++;
`endif
    prev_pulse = rx_done_tick | frame_err;
  end

  // Reference model: what a frame should produce, from the line-level description alone.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_perr = 0;
  logic [7:0] exp_dout = 8'h00;

  task automatic model_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    if (stop_bit) begin
      exp_q.push_back(data & MASK);
      exp_dout = data & MASK;
    end else begin
      exp_ferr++;
    end
`ifdef UART_RX_PARITY_EN
    if (par_bit != ^(data & MASK)) exp_perr++;
`else
    if (par_bit === 1'bx) exp_perr = exp_perr;
`endif
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, {24'd0, obs_q.pop_front()}, {24'd0, exp_q.pop_front()});
    obs_q.delete();
    exp_q.delete();
    check({tag, "_ferr"}, ferr_seen, exp_ferr);
    check({tag, "_perr"}, perr_seen, exp_perr);
    check({tag, "_dout"}, {24'd0, rx_dout}, {24'd0, exp_dout});
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!s_tick);
    end
    @(negedge clk);
  endtask

  // Drives one frame; abort_bit >= 0 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bit, input int abort_bit);
    rx = 1'b0;
    start_tick = tick_total;
    wait_ticks(16);
    for (int i = 0; i < DBIT; i++) begin
      rx = data[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        return;
      end
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    wait_ticks(16);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    rx = stop_bit;
    // A low stop bit is released early so the re-armed receiver sees a glitch, not a new frame.
    wait_ticks(stop_bit ? 16 : 10);
    rx = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [7:0] data,
                       input logic stop_bit, input logic par_bit);
    model_frame(data, stop_bit, par_bit);
    send_frame(data, stop_bit, par_bit, -1);
    if (!stop_bit) wait_ticks(20);
    compare(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       sb;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_dout", {24'd0, rx_dout}, 32'd0);
    check("reset_done", {31'd0, rx_done_tick}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    wait_ticks(4);

    // Start-bit glitch straight after reset: nothing happens, dout stays 0.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(24);
    compare("glitch");

    frame("a5", 8'hA5, 1'b1, ^8'hA5);
    check("a5_latency", {31'd0, (last_lat == 152 || last_lat == 153)}, 32'd1);
    wait_ticks(4);

    frame("bad_stop", 8'h3C, 1'b0, ^8'h3C);

    model_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, -1);
    model_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    compare("b2b");

    send_frame(8'h81, 1'b1, 1'b0, 4);
    exp_dout = 8'h00;
    check("abort_dout", {24'd0, rx_dout}, 32'd0);
    wait_ticks(8);
    compare("abort");
    frame("after_abort", 8'h42, 1'b1, ^8'h42);

`ifdef UART_RX_PARITY_EN
    wait_ticks(4);
    frame("par_bad", 8'h07, 1'b1, 1'b0);
    wait_ticks(4);
    frame("par_ok", 8'h07, 1'b1, 1'b1);
`endif

    for (int k = 0; k < 20; k++) begin
      tick_period = 4 + int'($urandom_range(2));
      wait_ticks(1 + int'($urandom_range(3)));
      d  = 8'($urandom);
      sb = ($urandom_range(7) != 0);
      frame("rand", d, sb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
